// File: rtl/grav_pair_scheduler.sv
// Timestep sequencer: clear accumulators, issue all i<j pairs to the force unit, drain, integrate (GRAV_STEP_PERF_EN adds cycle count).
// Latency: one clear per cycle, up to one pair per cycle, one integrate per handshake; DONE one cycle after the last integrate.
// Backpressure: pairs gated by PAIR_READY and the in-flight limit; integrates held until INT_READY; requests never withdrawn.
module grav_pair_scheduler #(
    parameter int N_BODIES     = 8,
    parameter int IDX_W        = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             STEP_START,
    input  logic [IDX_W:0]   N_ACTIVE,
    output logic             STEP_DONE,
    output logic             BUSY,
    output logic             CLR_VALID,
    output logic [IDX_W-1:0] CLR_IDX,
    output logic             PAIR_VALID,
    input  logic             PAIR_READY,
    output logic [IDX_W-1:0] PAIR_I,
    output logic [IDX_W-1:0] PAIR_J,
    input  logic             RES_VALID,
    output logic             INT_VALID,
    input  logic             INT_READY,
    output logic [IDX_W-1:0] INT_IDX,
    output logic             ERR,
    output logic [31:0]      STEP_CYCLES
);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IDX_W:0]   N_ONE   = 1;
    localparam logic [IDX_W:0]   N_TWO   = 2;
    localparam logic [IDX_W:0]   N_MAX   = (IDX_W+1)'(N_BODIES);
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [IDX_W-1:0] IDX_TWO = 2;
    localparam logic [INF_W-1:0] INF_ONE = 1;
    localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PAIRS, S_DRAIN, S_INTEGRATE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W:0]   n_q, n_d, n_sel;
    logic [IDX_W-1:0] k_q, k_d, i_q, i_d, j_q, j_d;
    logic [INF_W-1:0] inflight_q;
    logic             err_q;
    logic             pair_hs, last_k, last_j, last_pair;

    assign n_sel     = (N_ACTIVE > N_MAX) ? N_MAX : N_ACTIVE;
    assign last_k    = ({1'b0, k_q} == n_q - N_ONE);
    assign last_j    = ({1'b0, j_q} == n_q - N_ONE);
    assign last_pair = last_j && ({1'b0, i_q} == n_q - N_TWO);

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign PAIR_VALID = (state_q == S_PAIRS) && (inflight_q < INF_MAX);
    assign pair_hs    = PAIR_VALID && PAIR_READY;
    assign CLR_VALID  = (state_q == S_CLEAR);
    assign INT_VALID  = (state_q == S_INTEGRATE);
    assign STEP_DONE  = (state_q == S_DONE);
    assign BUSY       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign CLR_IDX    = k_q;
    assign INT_IDX    = k_q;
    assign PAIR_I     = i_q;
    assign PAIR_J     = j_q;
    assign ERR        = err_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            S_IDLE: if (STEP_START) begin
                n_d     = n_sel;
                k_d     = '0;
                state_d = (n_sel == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: if (last_k) begin
                if (n_q >= N_TWO) begin
                    state_d = S_PAIRS;
                    i_d     = '0;
                    j_d     = IDX_ONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end else begin
                k_d = k_q + IDX_ONE;
            end
            S_PAIRS: if (pair_hs) begin
                if (last_pair) begin
                    state_d = S_DRAIN;
                end else if (last_j) begin
                    i_d = i_q + IDX_ONE;
                    j_d = i_q + IDX_TWO;
                end else begin
                    j_d = j_q + IDX_ONE;
                end
            end
            S_DRAIN: if (inflight_q == '0) begin
                state_d = S_INTEGRATE;
                k_d     = '0;
            end
            S_INTEGRATE: if (INT_READY) begin
                if (last_k) state_d = S_DONE;
                else        k_d     = k_q + IDX_ONE;
            end
            S_DONE: if (!STEP_START) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // A result with nothing outstanding is dropped and latched as a protocol error.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else if (pair_hs && !RES_VALID) begin
            inflight_q <= inflight_q + INF_ONE;
        end else if (!pair_hs && RES_VALID) begin
            if (inflight_q == '0) err_q      <= 1'b1;
            else                  inflight_q <= inflight_q - INF_ONE;
        end
    end

`ifdef GRAV_STEP_PERF_EN
    logic [31:0] cyc_q, cyc_d, step_cycles_q;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE && STEP_START) cyc_d = '0;
        else if (BUSY && cyc_q != '1)        cyc_d = cyc_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cyc_q         <= '0;
            step_cycles_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            if (state_d == S_DONE && state_q != S_DONE) step_cycles_q <= cyc_d;
        end
    end

    assign STEP_CYCLES = step_cycles_q;
`else
    assign STEP_CYCLES = '0;
`endif
endmodule

// File: tb/tb_grav_pair_scheduler.sv
// Randomized scoreboard bench for grav_pair_scheduler: expected clear/pair/integrate sequences queued per step, monitor pops on handshakes.
module tb_grav_pair_scheduler;
    localparam int NB = 8;
    localparam int IW = 4;
    localparam int MI = 4;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          STEP_START = 1'b0;
    logic [IW:0]   N_ACTIVE = '0;
    logic          STEP_DONE, BUSY, CLR_VALID, PAIR_VALID, INT_VALID, ERR;
    logic [IW-1:0] CLR_IDX, PAIR_I, PAIR_J, INT_IDX;
    logic          PAIR_READY = 1'b0;
    logic          RES_VALID = 1'b0;
    logic          INT_READY = 1'b0;
    logic [31:0]   STEP_CYCLES;

    grav_pair_scheduler #(.N_BODIES(NB), .IDX_W(IW), .MAX_INFLIGHT(MI)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .STEP_START(STEP_START), .N_ACTIVE(N_ACTIVE),
        .STEP_DONE(STEP_DONE), .BUSY(BUSY), .CLR_VALID(CLR_VALID), .CLR_IDX(CLR_IDX),
        .PAIR_VALID(PAIR_VALID), .PAIR_READY(PAIR_READY), .PAIR_I(PAIR_I), .PAIR_J(PAIR_J),
        .RES_VALID(RES_VALID), .INT_VALID(INT_VALID), .INT_READY(INT_READY), .INT_IDX(INT_IDX),
        .ERR(ERR), .STEP_CYCLES(STEP_CYCLES));

    always #5 CLK = ~CLK;

    int     checks = 0;
    int     errors = 0;
    int     exp_clr[$];
    int     exp_pair[$];
    int     exp_int[$];
    longint res_due[$];
    longint cyc = 0;
    int     model_inflight = 0;
    bit     model_err = 1'b0;
    int     hs_count = 0;
    int     busy_cnt = 0;
    int     ready_mode = 0;
    int     int_mode = 0;
    int     dly_min = 0;
    int     dly_max = 0;
    bit     hold_res = 1'b0;
    int     res_credit = 0;
    bit     spurious_req = 1'b0;
    bit     prev_clr = 1'b0;
    bit     prev_stall = 1'b0;
    int     prev_ij = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got strobe %0d expected none", name, act);
    endtask

    // Stimulus driver: readies and force results, changed just after the rising edge.
    always @(posedge CLK) begin
        #1;
        cyc++;
        RES_VALID = 1'b0;
        if (RESET_N) begin
            if (spurious_req) begin
                RES_VALID    = 1'b1;
                spurious_req = 1'b0;
            end else if (res_due.size() > 0 && res_due[0] <= cyc && (!hold_res || res_credit > 0)) begin
                RES_VALID = 1'b1;
                void'(res_due.pop_front());
                if (hold_res) res_credit--;
            end
        end
        case (ready_mode)
            0:       PAIR_READY = 1'b1;
            1:       PAIR_READY = ~PAIR_READY;
            default: PAIR_READY = ($urandom_range(0, 1) == 1);
        endcase
        INT_READY = (int_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end

    // Monitor: samples on the falling edge, pops expectations on each handshake.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            prev_clr   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("err_flag", ERR, model_err);
            if (CLR_VALID) begin
                if (CLR_IDX != 0) chk("clr_consecutive", prev_clr, 1);
                if (exp_clr.size() == 0) extra("clr_extra", CLR_IDX);
                else chk("clr_idx", CLR_IDX, exp_clr.pop_front());
            end
            if (prev_stall) begin
                chk("pair_held_valid", PAIR_VALID, 1);
                chk("pair_held_ij", int'(PAIR_I) * 16 + int'(PAIR_J), prev_ij);
            end
            if (PAIR_VALID) chk("inflight_bound", model_inflight < MI, 1);
            if (PAIR_VALID && PAIR_READY) begin
                hs_count++;
                if (exp_pair.size() == 0) extra("pair_extra", int'(PAIR_I) * 16 + int'(PAIR_J));
                else chk("pair_ij", int'(PAIR_I) * 16 + int'(PAIR_J), exp_pair.pop_front());
                res_due.push_back(cyc + 1 + $urandom_range(dly_min, dly_max));
            end
            if (INT_VALID && INT_READY) begin
                if (exp_int.size() == 0) extra("int_extra", INT_IDX);
                else chk("int_idx", INT_IDX, exp_int.pop_front());
            end
            if (PAIR_VALID && PAIR_READY && !RES_VALID) model_inflight++;
            else if (!(PAIR_VALID && PAIR_READY) && RES_VALID) begin
                if (model_inflight == 0) model_err = 1'b1;
                else model_inflight--;
            end
            if (STEP_DONE) chk("done_not_busy", BUSY, 0);
            if (BUSY) busy_cnt++;
            prev_clr   = CLR_VALID;
            prev_stall = PAIR_VALID && !PAIR_READY;
            prev_ij    = int'(PAIR_I) * 16 + int'(PAIR_J);
        end
    end

    task automatic start_step(input int na, input int rmode, input int dmin, input int dmax, input int imode);
        int n;
        n = (na > NB) ? NB : na;
        for (int a = 0; a < n; a++) exp_clr.push_back(a);
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++) exp_pair.push_back(a * 16 + b);
        for (int a = 0; a < n; a++) exp_int.push_back(a);
        ready_mode = rmode;
        dly_min    = dmin;
        dly_max    = dmax;
        int_mode   = imode;
        busy_cnt   = 0;
        hs_count   = 0;
        @(posedge CLK);
        #1;
        N_ACTIVE   = (IW+1)'(na);
        STEP_START = 1'b1;
    endtask

    task automatic finish_step();
        int t;
        longint exp_cycles;
        t = 0;
        while (STEP_DONE !== 1'b1 && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: got no STEP_DONE in %0d cycles, required STEP_DONE=1", t);
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge CLK);
            chk("done_hold", STEP_DONE, 1);
        end
        chk("clr_left", exp_clr.size(), 0);
        chk("pair_left", exp_pair.size(), 0);
        chk("int_left", exp_int.size(), 0);
`ifdef GRAV_STEP_PERF_EN
        exp_cycles = busy_cnt;
`else
        exp_cycles = 0;
`endif
        chk("step_cycles", STEP_CYCLES, exp_cycles);
        @(posedge CLK);
        #1;
        STEP_START = 1'b0;
        repeat (2) @(negedge CLK);
        chk("back_idle_done", STEP_DONE, 0);
        chk("back_idle_busy", BUSY, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, STEP_DONE, 0);
        chk({tag, "_clr_vld"}, CLR_VALID, 0);
        chk({tag, "_pair_vld"}, PAIR_VALID, 0);
        chk({tag, "_int_vld"}, INT_VALID, 0);
        chk({tag, "_err"}, ERR, 0);
        chk({tag, "_idx"}, int'(CLR_IDX) + int'(PAIR_I) + int'(PAIR_J) + int'(INT_IDX), 0);
        chk({tag, "_cycles"}, STEP_CYCLES, 0);
    endtask

    initial begin
        int t;
        #2;
        chk_all_zero("reset");
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        start_step(4, 0, 1, 1, 0);
        finish_step();
        start_step(1, 0, 1, 1, 0);
        finish_step();
        start_step(0, 0, 1, 1, 0);
        finish_step();
        start_step(12, 0, 0, 3, 0);
        finish_step();
        start_step(4, 1, 0, 0, 0);
        finish_step();
        start_step(2, 0, 0, 0, 0);
        finish_step();
        for (int r = 0; r < 6; r++) begin
            start_step($urandom_range(0, 12), 2, 0, 6, 1);
            finish_step();
        end

        // Starve the force unit of results: the in-flight limit must stop issue.
        hold_res   = 1'b1;
        res_credit = 0;
        start_step(8, 0, 0, 0, 0);
        repeat (60) @(negedge CLK);
        chk("stall_hs_count", hs_count, MI);
        chk("stall_pair_vld", PAIR_VALID, 0);
        res_credit = 1;
        repeat (20) @(negedge CLK);
        chk("release_one_hs", hs_count, MI + 1);
        chk("release_one_vld", PAIR_VALID, 0);
        hold_res = 1'b0;
        finish_step();

        spurious_req = 1'b1;
        repeat (3) @(negedge CLK);
        chk("spurious_err", ERR, 1);
        start_step(3, 2, 0, 4, 1);
        finish_step();
        chk("err_sticky", ERR, 1);

        // Reset mid-PAIRS, then a clean restart.
        start_step(8, 0, 3, 5, 0);
        t = 0;
        while (hs_count < 3 && t < 500) begin
            @(negedge CLK);
            t++;
        end
        chk("reached_pairs", hs_count >= 3, 1);
        @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_clr.delete();
        exp_pair.delete();
        exp_int.delete();
        res_due.delete();
        model_inflight = 0;
        model_err      = 1'b0;
        STEP_START     = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        start_step(5, 2, 0, 3, 1);
        finish_step();
        start_step(2, 0, 0, 0, 0);
        finish_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
